// File: rtl/cordic_rot_iter.sv
// Iterative rotation-mode CORDIC: rotates (xin, yin) by a signed angle using one
// micro-rotation per clock, with quadrant folding, guard bits and round-and-saturate.
module cordic_rot_iter #(
  parameter int W     = 8,
  parameter int ITER  = 8,
  parameter int GUARD = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] xin,
  input  logic signed [W-1:0] yin,
  input  logic signed [W-1:0] angle,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] xout,
  output logic signed [W-1:0] yout
);

  localparam int F  = W - 2;
  localparam int IW = W + GUARD + 2;
  localparam int SH = 30 - F - GUARD;
  localparam int CW = 5;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic logic signed [IW-1:0] q30_scale(input longint v);
    longint r;
    r = (v + (longint'(1) << (SH - 1))) >>> SH;
    return IW'(r);
  endfunction

  function automatic longint atan_q30(input int i);
    case (i)
      0:       return 64'sd843314857;
      1:       return 64'sd497837829;
      2:       return 64'sd263043837;
      3:       return 64'sd133525159;
      4:       return 64'sd67021687;
      5:       return 64'sd33543516;
      6:       return 64'sd16775851;
      7:       return 64'sd8388437;
      8:       return 64'sd4194283;
      9:       return 64'sd2097149;
      10:      return 64'sd1048576;
      11:      return 64'sd524288;
      12:      return 64'sd262144;
      13:      return 64'sd131072;
      14:      return 64'sd65536;
      default: return 64'sd32768;
    endcase
  endfunction

  function automatic logic [16*IW-1:0] build_tab();
    logic [16*IW-1:0] t;
    t = '0;
    for (int i = 0; i < 16; i++) t[i*IW +: IW] = q30_scale(atan_q30(i));
    return t;
  endfunction

  localparam logic [16*IW-1:0]     ATAN_P  = build_tab();
  localparam logic signed [IW-1:0] HP      = q30_scale(64'sd1686629713);
  localparam logic signed [IW:0]   RND     = (IW+1)'(1 << (GUARD - 1));
  localparam logic signed [IW:0]   SAT_MAX = (IW+1)'((1 << (W - 1)) - 1);
  localparam logic signed [IW:0]   SAT_MIN = (IW+1)'(-(1 << (W - 1)));

  function automatic logic signed [IW-1:0] widen(input logic signed [W-1:0] v);
    return {{2{v[W-1]}}, v, {GUARD{1'b0}}};
  endfunction

  // Drop the guard bits with round-half-up, then clamp to the output range.
  function automatic logic signed [W-1:0] round_sat(input logic signed [IW-1:0] v);
    logic signed [IW:0] t;
    t = ($signed({v[IW-1], v}) + RND) >>> GUARD;
    if (t > SAT_MAX)      return SAT_MAX[W-1:0];
    else if (t < SAT_MIN) return SAT_MIN[W-1:0];
    else                  return t[W-1:0];
  endfunction

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  out_valid_q, out_valid_d;
  logic signed [W-1:0]   xout_q, xout_d, yout_q, yout_d;
  logic signed [IW-1:0]  x_q, x_d, y_q, y_d, z_q, z_d;
  logic signed [IW-1:0]  xs, ys, zs, x_rot, y_rot, z_rot, atan_i;
  logic                  accept;

  assign in_ready  = (state_q == IDLE) || (state_q == DONE && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign xout      = xout_q;
  assign yout      = yout_q;

  always_comb begin
    xs     = widen(xin);
    ys     = widen(yin);
    zs     = widen(angle);
    atan_i = ATAN_P[int'(cnt_q)*IW +: IW];
    if (!z_q[IW-1]) begin
      x_rot = x_q - (y_q >>> cnt_q);
      y_rot = y_q + (x_q >>> cnt_q);
      z_rot = z_q - atan_i;
    end else begin
      x_rot = x_q + (y_q >>> cnt_q);
      y_rot = y_q - (x_q >>> cnt_q);
      z_rot = z_q + atan_i;
    end

    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    xout_d      = xout_q;
    yout_d      = yout_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;

    case (state_q)
      RUN: begin
        x_d = x_rot;
        y_d = y_rot;
        z_d = z_rot;
        if (cnt_q == CW'(ITER - 1)) begin
          xout_d      = round_sat(x_rot);
          yout_d      = round_sat(y_rot);
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: ;
    endcase

    // Fold angles beyond +-pi/2 by a quarter turn so the micro-rotations converge.
    if (accept) begin
      if (zs > HP) begin
        x_d = -ys;
        y_d = xs;
        z_d = zs - HP;
      end else if (zs < -HP) begin
        x_d = ys;
        y_d = -xs;
        z_d = zs + HP;
      end else begin
        x_d = xs;
        y_d = ys;
        z_d = zs;
      end
      cnt_d       = '0;
      out_valid_d = 1'b0;
      state_d     = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      xout_q      <= '0;
      yout_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      xout_q      <= xout_d;
      yout_q      <= yout_d;
    end
  end

  always_ff @(posedge clk) begin
    x_q <= x_d;
    y_q <= y_d;
    z_q <= z_d;
  end

endmodule

// File: tb/tb_cordic_rot_iter.sv
// Bench for cordic_rot_iter: a real-valued rotation model checked every cycle on the
// default instance, hand-computed literals, and a wider instance for the parameter sweep.
module tb_cordic_rot_iter;

  localparam int W      = 8;
  localparam int ITER   = 8;
  localparam int GUARD  = 3;
  localparam int W2     = 12;
  localparam int ITER2  = 12;
  localparam int GUARD2 = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic                in_valid = 1'b0, out_ready = 1'b0;
  logic                in_ready, out_valid;
  logic signed [W-1:0] xin = '0, yin = '0, angle = '0;
  logic signed [W-1:0] xout, yout;

  logic                 b_in_valid = 1'b0, b_out_ready = 1'b1;
  logic                 b_in_ready, b_out_valid;
  logic signed [W2-1:0] b_xin = '0, b_yin = '0, b_angle = '0;
  logic signed [W2-1:0] b_xout, b_yout;

  cordic_rot_iter #(.W(W), .ITER(ITER), .GUARD(GUARD)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .xin(xin), .yin(yin), .angle(angle), .out_valid(out_valid),
    .out_ready(out_ready), .xout(xout), .yout(yout)
  );

  cordic_rot_iter #(.W(W2), .ITER(ITER2), .GUARD(GUARD2)) dut_b (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .xin(b_xin), .yin(b_yin), .angle(b_angle), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .xout(b_xout), .yout(b_yout)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check_int(input string name, input int act, input int lo, input int hi);
    n_chk++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic check_near(input string name, input int act, input real exp, input real tol);
    real d;
    d = act - exp;
    if (d < 0.0) d = -d;
    n_chk++;
    if (d > tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %f +- %f", name, act, exp, tol);
    end
  endtask

  function automatic real gain(input int iters);
    real g;
    g = 1.0;
    for (int i = 0; i < iters; i++) g = g * $sqrt(1.0 + 2.0 ** (-2 * i));
    return g;
  endfunction

  // Ideal rotation scaled by the CORDIC gain, clamped to the output code range.
  function automatic real model_out(input bit want_y, input int xi, input int yi,
                                    input int ai, input int iters, input int w);
    real s, x, y, a, r;
    s = 2.0 ** (w - 2);
    x = xi / s;
    y = yi / s;
    a = ai / s;
    r = want_y ? (x * $sin(a) + y * $cos(a)) : (x * $cos(a) - y * $sin(a));
    r = r * gain(iters) * s;
    if (r > 2.0 ** (w - 1) - 1.0) r = 2.0 ** (w - 1) - 1.0;
    if (r < -(2.0 ** (w - 1)))    r = -(2.0 ** (w - 1));
    return r;
  endfunction

  // Per-cycle scoreboard: state after each rising edge is predicted at the preceding
  // falling edge from the inputs that edge will sample.
  initial begin
    bit   known = 0, have = 0, zero = 0, held = 0, acc, mrdy;
    int   run = 0;
    real  ex = 0.0, ey = 0.0, px = 0.0, py = 0.0;
    int   hx = 0, hy = 0;
    forever begin
      @(negedge clk);
      mrdy = (run == 0) && (!have || out_ready);
      if (known) begin
        check_bit("out_valid", out_valid, have);
        check_bit("in_ready", in_ready, mrdy);
        if (have) begin
          check_near("model_x", int'(xout), ex, 2.0);
          check_near("model_y", int'(yout), ey, 2.0);
          if (held) begin
            check_int("hold_x", int'(xout), hx, hx);
            check_int("hold_y", int'(yout), hy, hy);
          end
        end else if (zero) begin
          check_int("reset_x", int'(xout), 0, 0);
          check_int("reset_y", int'(yout), 0, 0);
        end
      end
      hx = int'(xout);
      hy = int'(yout);
      if (reset) begin
        known = 1; have = 0; run = 0; zero = 1; held = 0;
      end else if (known) begin
        acc  = in_valid && mrdy;
        held = have && !out_ready;
        if (have && out_ready) have = 0;
        if (run > 0) begin
          run--;
          if (run == 0) begin
            have = 1; zero = 0; held = 0; ex = px; ey = py;
          end
        end
        if (acc) begin
          run = ITER;
          px  = model_out(0, int'(xin), int'(yin), int'(angle), ITER, W);
          py  = model_out(1, int'(xin), int'(yin), int'(angle), ITER, W);
        end
      end
    end
  end

  task automatic drive_a(input int x, input int y, input int a);
    xin = W'(x); yin = W'(y); angle = W'(a); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_a(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_a(input string name, input int x, input int y, input int a,
                       input int xlo, input int xhi, input int ylo, input int yhi);
    int n;
    out_ready = 1'b0;
    drive_a(x, y, a);
    wait_a(n);
    check_int({name, "_lat"}, n, ITER, ITER);
    check_int({name, "_x"}, int'(xout), xlo, xhi);
    check_int({name, "_y"}, int'(yout), ylo, yhi);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_b(input string name, input int x, input int y, input int a);
    int n;
    b_xin = W2'(x); b_yin = W2'(y); b_angle = W2'(a); b_in_valid = 1'b1;
    check_bit({name, "_rdy"}, b_in_ready, 1'b1);
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    n = 0;
    while (!b_out_valid && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check_int({name, "_lat"}, n, ITER2, ITER2);
    check_near({name, "_x"}, int'(b_xout), model_out(0, x, y, a, ITER2, W2), 2.0);
    check_near({name, "_y"}, int'(b_yout), model_out(1, x, y, a, ITER2, W2), 2.0);
    @(posedge clk); #1;
  endtask

  initial begin
    int n, cnt, hx;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_bit("rst_in_ready", in_ready, 1'b1);
    check_bit("rst_out_valid", out_valid, 1'b0);
    check_int("rst_xout", int'(xout), 0, 0);
    check_int("rst_yout", int'(yout), 0, 0);

    run_a("a00", 39, 0, 8'sh00, 63, 65, -1, 1);
    run_a("a43", 39, 0, 8'sh43, 30, 34, 53, 57);
    run_a("a64", 39, 0, 8'sh64, 0, 2, 63, 65);
    run_a("a7f", 39, 0, 8'sh7F, -28, -24, 56, 60);
    run_a("a80", 39, 0, -128, -29, -25, -60, -56);

    // Backpressure, requests ignored while busy, then back-to-back accept.
    out_ready = 1'b0;
    drive_a(39, 0, 8'sh20);
    in_valid = 1'b1; angle = 8'sh10;
    repeat (3) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    wait_a(n);
    check_bit("bp_valid", out_valid, 1'b1);
    hx = int'(xout);
    repeat (5) begin
      @(posedge clk); #1;
      check_bit("bp_out_valid", out_valid, 1'b1);
      check_bit("bp_in_ready", in_ready, 1'b0);
      check_int("bp_stable_x", int'(xout), hx, hx);
    end
    out_ready = 1'b1;
    drive_a(39, 0, -89);
    out_ready = 1'b0;
    wait_a(n);
    check_int("b2b_lat", n, ITER, ITER);
    check_int("b2b_x", int'(xout), 9, 13);
    check_int("b2b_y", int'(yout), -65, -61);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset in the middle of a rotation.
    drive_a(39, 0, 8'sh30);
    repeat (4) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_bit("mid_rst_valid", out_valid, 1'b0);
    check_bit("mid_rst_ready", in_ready, 1'b1);
    check_int("mid_rst_x", int'(xout), 0, 0);
    check_int("mid_rst_y", int'(yout), 0, 0);
    cnt = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) cnt++;
    end
    check_int("mid_rst_stale", cnt, 0, 0);

    for (int k = 0; k < 6; k++)
      run_a("rnd8", 39, 0, int'($signed(8'($urandom_range(0, 255)))), -128, 127, -128, 127);

    run_b("w12_a0", 622, 0, 0);
    for (int k = 0; k < 10; k++)
      run_b("w12_rnd", 622, 0, int'($signed(12'($urandom_range(0, 4095)))));
    run_b("w12_satp", 2047, 2047, 0);
    check_int("satp_x", int'(b_xout), 2047, 2047);
    check_int("satp_y", int'(b_yout), 2047, 2047);
    run_b("w12_satn", -2048, -2048, 0);
    check_int("satn_x", int'(b_xout), -2048, -2048);
    check_int("satn_y", int'(b_yout), -2048, -2048);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
